// File: rtl/mealy_fsm_decoder_if.sv
// Coded-bit input channel and recovered-word output channel of the Mealy line decoder.
interface mealy_fsm_decoder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             z_in;
    logic             sync;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, z_in, sync, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, z_in, sync, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mealy_fsm_decoder.sv
// Tracks the 3-state Mealy encoder in lockstep, recovers x from each coded bit z and
// packs recovered bits LSB-first into WIDTH-bit words held in a single output register.
module mealy_fsm_decoder #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mealy_fsm_decoder_if.slave   bus,
    output logic [1:0]           state_dbg
);
    localparam logic [1:0] ST_A = 2'b00;
    localparam logic [1:0] ST_B = 2'b01;
    localparam logic [1:0] ST_C = 2'b10;
    localparam int         CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    bit_cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] word_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             x_d;
    logic             last_d;
    logic             in_rdy_d;
    logic             accept_d;

    always_comb begin
        x_d     = (state_q == ST_C) ? ~bus.z_in : bus.z_in;
        state_d = ST_A;
        case (state_q)
            ST_A:    state_d = x_d ? ST_B : ST_A;
            ST_B:    state_d = x_d ? ST_A : ST_C;
            ST_C:    state_d = x_d ? ST_C : ST_B;
            default: state_d = ST_A;
        endcase
        last_d   = (bit_cnt_q == LAST);
        // Only the completing bit can stall: it needs the holding register free.
        in_rdy_d = !bus.sync && !(last_d && out_valid_q && !bus.out_ready);
        accept_d = bus.in_valid && in_rdy_d;
        word_d   = shift_q;
        word_d[bit_cnt_q] = x_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_A;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (bus.sync) begin
                state_q   <= ST_A;
                bit_cnt_q <= '0;
                shift_q   <= '0;
            end else if (accept_d) begin
                state_q <= state_d;
                if (last_d) begin
                    bit_cnt_q <= '0;
                    shift_q   <= '0;
                end else begin
                    bit_cnt_q <= bit_cnt_q + CW'(1);
                    shift_q   <= word_d;
                end
            end

            if (accept_d && last_d) begin
                out_valid_q <= 1'b1;
                out_data_q  <= word_d;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_rdy_d;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_mealy_fsm_decoder.sv
// Directed vector table on a WIDTH=4 decoder plus a random encoded stream on a WIDTH=8 decoder.
module tb_mealy_fsm_decoder;
    logic clk;
    logic rst;
    logic [1:0] st4;
    logic [1:0] st8;
    int checks;
    int errors;

    mealy_fsm_decoder_if #(.WIDTH(4)) bus4 ();
    mealy_fsm_decoder_if #(.WIDTH(8)) bus8 ();

    mealy_fsm_decoder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave), .state_dbg(st4));
    mealy_fsm_decoder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave), .state_dbg(st8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sync;
        logic       iv;
        logic       z;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [3:0] e_od;
        logic [1:0] e_st;
    } vec_t;

    vec_t vecs[32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference encoder: returns {next_state, z}
    function automatic logic [2:0] enc(input logic [1:0] s, input logic x);
        case (s)
            2'd0:    enc = x ? {2'd1, 1'b1} : {2'd0, 1'b0};
            2'd1:    enc = x ? {2'd0, 1'b1} : {2'd2, 1'b0};
            default: enc = x ? {2'd2, 1'b0} : {2'd1, 1'b1};
        endcase
    endfunction

    task automatic drive4(input logic s, input logic iv, input logic z, input logic o);
        bus4.sync      = s;
        bus4.in_valid  = iv;
        bus4.z_in      = z;
        bus4.out_ready = o;
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] acc;
        logic [7:0] got;
        logic [2:0] e;
        logic [1:0] es;
        logic       cur_x;
        int         nacc;
        int         bits_sent;
        int         words_rx;
        int         cyc;

        checks = 0;
        errors = 0;
        //           sync iv z  ordy ir ov od     st
        vecs[0]  = '{0, 0, 0, 1, 1, 0, 4'h0, 2'd0};
        vecs[1]  = '{0, 1, 1, 1, 1, 0, 4'h0, 2'd0};
        vecs[2]  = '{0, 1, 0, 1, 1, 0, 4'h0, 2'd1};
        vecs[3]  = '{0, 1, 0, 1, 1, 0, 4'h0, 2'd2};
        vecs[4]  = '{0, 1, 0, 1, 1, 0, 4'h0, 2'd2};
        vecs[5]  = '{0, 0, 0, 1, 1, 1, 4'hD, 2'd2};
        vecs[6]  = '{0, 0, 0, 0, 1, 0, 4'hD, 2'd2};
        vecs[7]  = '{0, 1, 1, 0, 1, 0, 4'hD, 2'd2};
        vecs[8]  = '{0, 1, 1, 0, 1, 0, 4'hD, 2'd1};
        vecs[9]  = '{0, 1, 0, 0, 1, 0, 4'hD, 2'd0};
        vecs[10] = '{0, 1, 1, 0, 1, 0, 4'hD, 2'd0};
        vecs[11] = '{0, 1, 1, 0, 1, 1, 4'hA, 2'd1};
        vecs[12] = '{0, 1, 0, 0, 1, 1, 4'hA, 2'd0};
        vecs[13] = '{0, 1, 1, 0, 1, 1, 4'hA, 2'd0};
        vecs[14] = '{0, 1, 1, 0, 0, 1, 4'hA, 2'd1};
        vecs[15] = '{0, 1, 1, 0, 0, 1, 4'hA, 2'd1};
        vecs[16] = '{0, 1, 1, 1, 1, 1, 4'hA, 2'd1};
        vecs[17] = '{0, 0, 0, 0, 1, 1, 4'hD, 2'd0};
        vecs[18] = '{0, 0, 0, 1, 1, 1, 4'hD, 2'd0};
        vecs[19] = '{0, 0, 0, 1, 1, 0, 4'hD, 2'd0};
        vecs[20] = '{0, 1, 1, 1, 1, 0, 4'hD, 2'd0};
        vecs[21] = '{0, 1, 0, 1, 1, 0, 4'hD, 2'd1};
        vecs[22] = '{1, 1, 1, 1, 0, 0, 4'hD, 2'd2};
        vecs[23] = '{0, 1, 0, 1, 1, 0, 4'hD, 2'd0};
        vecs[24] = '{0, 1, 1, 1, 1, 0, 4'hD, 2'd0};
        vecs[25] = '{0, 1, 1, 1, 1, 0, 4'hD, 2'd1};
        vecs[26] = '{0, 1, 0, 1, 1, 0, 4'hD, 2'd0};
        vecs[27] = '{0, 0, 0, 0, 1, 1, 4'h6, 2'd0};
        vecs[28] = '{1, 0, 0, 0, 0, 1, 4'h6, 2'd0};
        vecs[29] = '{0, 0, 0, 0, 1, 1, 4'h6, 2'd0};
        vecs[30] = '{0, 0, 0, 1, 1, 1, 4'h6, 2'd0};
        vecs[31] = '{0, 0, 0, 1, 1, 0, 4'h6, 2'd0};

        drive4(0, 0, 0, 1);
        bus8.sync = 0; bus8.in_valid = 0; bus8.z_in = 0; bus8.out_ready = 0;
        rst = 1'b1;
        #1;
        chk("reset_out_valid", {31'd0, bus4.out_valid}, 32'd0);
        chk("reset_out_data", {28'd0, bus4.out_data}, 32'd0);
        chk("reset_state", {30'd0, st4}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive4(vecs[i].sync, vecs[i].iv, vecs[i].z, vecs[i].ordy);
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'd0, bus4.in_ready}, {31'd0, vecs[i].e_ir});
            chk($sformatf("v%0d_out_valid", i), {31'd0, bus4.out_valid}, {31'd0, vecs[i].e_ov});
            chk($sformatf("v%0d_out_data", i), {28'd0, bus4.out_data}, {28'd0, vecs[i].e_od});
            chk($sformatf("v%0d_state", i), {30'd0, st4}, {30'd0, vecs[i].e_st});
        end

        // Illegal tracker state: decodes x=z and returns to A
        @(negedge clk);
        force dut4.state_q = 2'b11;
        drive4(0, 1, 1, 0);
        #1;
        chk("illegal_state_seen", {30'd0, st4}, 32'd3);
        #2;
        release dut4.state_q;
        @(negedge clk);
        #1;
        chk("illegal_next_state", {30'd0, st4}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            drive4(0, 1, 0, 0);
        end
        @(negedge clk);
        drive4(0, 0, 0, 0);
        #1;
        chk("illegal_word_valid", {31'd0, bus4.out_valid}, 32'd1);
        chk("illegal_word_data", {28'd0, bus4.out_data}, 32'h1);

        // Async reset mid-word while a word is held
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive4(0, 1, (i == 0) ? 1'b1 : 1'b0, 0);
        end
        @(negedge clk);
        drive4(0, 0, 0, 0);
        #1;
        chk("pre_rst_valid", {31'd0, bus4.out_valid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, bus4.out_valid}, 32'd0);
        chk("async_rst_data", {28'd0, bus4.out_data}, 32'd0);
        chk("async_rst_state", {30'd0, st4}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive4(0, 1, (i == 0) ? 1'b1 : 1'b0, 1);
        end
        @(negedge clk);
        drive4(0, 0, 0, 1);
        #1;
        chk("post_rst_valid", {31'd0, bus4.out_valid}, 32'd1);
        chk("post_rst_data", {28'd0, bus4.out_data}, 32'hD);

        // Random 1000-bit stream through the reference encoder, WIDTH=8
        es = 2'd0;
        acc = '0;
        nacc = 0;
        bits_sent = 0;
        words_rx = 0;
        cyc = 0;
        cur_x = 1'($urandom_range(0, 1));
        while (words_rx < 125 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            e = enc(es, cur_x);
            bus8.in_valid  = (bits_sent < 1000) && ($urandom_range(0, 3) != 0);
            bus8.z_in      = e[0];
            bus8.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (bus8.out_valid && bus8.out_ready) begin
                got = bus8.out_data;
                if (exp_q.size() == 0) begin
                    chk($sformatf("rand_extra_word_%0d", words_rx), 32'd1, 32'd0);
                end else begin
                    chk($sformatf("rand_word_%0d", words_rx), {24'd0, got}, {24'd0, exp_q.pop_front()});
                end
                words_rx++;
            end
            if (bus8.in_valid && bus8.in_ready) begin
                acc[nacc] = cur_x;
                nacc++;
                if (nacc == 8) begin
                    exp_q.push_back(acc);
                    acc = '0;
                    nacc = 0;
                end
                es = e[2:1];
                bits_sent++;
                cur_x = 1'($urandom_range(0, 1));
            end
        end
        bus8.in_valid = 0;
        chk("rand_word_count", words_rx, 32'd125);
        chk("rand_queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mealy_fsm_decoder.md
Name: mealy_fsm_decoder

Overview:
Receive-side inverse of the team's 3-state Mealy line code. It recovers the original data bit x from each coded bit z, tracking the encoder state in lockstep. It packs recovered bits LSB-first into WIDTH-bit words and hands them downstream over a valid/ready interface. It sits at the far end of the serial link, fed by the link sampler, with sync driven by the framing logic.

Parameters:
WIDTH, 8, recovered word width in bits (legal range 2..32)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  z_in carries a coded bit this cycle
in_ready  output  1  decoder can accept a coded bit this cycle
z_in  input  1  coded bit (encoder output z)
sync  input  1  frame restart: tracker to state A, discard partial word
out_valid  output  1  out_data holds a complete word
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  WIDTH  recovered word; bit 0 = first recovered bit
state_dbg  output  2  current tracker state (debug)

Behaviour:
- Reset: asynchronous, active-high, from one clock with async reset. Reset values: tracker=A (2'b00), bit_cnt=0, shift register=0, out_valid=0, out_data=0, state_dbg=00.
- Encoder code (state, x -> z, next state):
  - A: x=0 -> z=0, next A; x=1 -> z=1, next B.
  - B: x=0 -> z=0, next C; x=1 -> z=1, next A.
  - C: x=0 -> z=1, next B; x=1 -> z=0, next C.
- Decode rule: x = z_in in states A and B; x = ~z_in in state C. The next tracker state follows the table using the recovered x. Combinational within the accept cycle; the tracker updates on the clock edge.
- Illegal state 2'b11: decodes x = z_in and transitions to A.
- Accept: a bit is taken when in_valid && in_ready && !sync.
- On accept, recovered x is written to shift position bit_cnt and bit_cnt increments.
- Word complete: when the accepted bit is the WIDTH-th (bit_cnt==WIDTH-1), on the next edge:
  - the full word loads into out_data;
  - out_valid goes to 1;
  - bit_cnt wraps to 0 and the shift register clears.
- Latency: out_valid rises exactly 1 cycle after the final bit is accepted.
- Output handshake:
  - out_valid && out_ready clears out_valid next edge, unless a new word loads on that same edge, in which case out_valid stays 1 with the new data.
  - out_data is stable while out_valid && !out_ready.
- in_ready = !sync && !(bit_cnt==WIDTH-1 && out_valid && !out_ready).
  - Partial-word bits are always accepted.
  - Only the completing bit stalls, and only when the holding register is occupied and not draining.
- sync:
  - Highest priority after rst.
  - Next edge: tracker=A, bit_cnt=0, shift register cleared.
  - Any in_valid bit that cycle is not accepted (in_ready=0).
  - out_valid and out_data are unaffected.
- Reset mid-word or mid-stall: all state is lost immediately (async), and an undelivered word is dropped.
- state_dbg is the registered tracker state.

Test Plan:
- WIDTH=4, after reset, feed z_in=1,0,0,0 (one per cycle, out_ready=1) -> out_data=4'hD, out_valid high for 1 cycle, 1 cycle after the 4th bit; state_dbg ends 2'b10 (C).
- WIDTH=4, out_ready=0, send 8 coded bits back-to-back -> first word held stable; in_ready=0 on the 8th bit until out_ready=1. That cycle the 8th bit is accepted and out_valid stays 1 with the second word.
- WIDTH=4, send 2 bits driving the tracker to C, assert sync for 1 cycle with in_valid=1 -> that bit is dropped; state_dbg=00; the next 4 bits z=0,1,1,0 -> out_data=4'b0110.
- Random 1000-bit x stream through a reference encoder model, WIDTH=8, random out_ready -> every decoded word matches x in order, with no loss or duplication.
- Force tracker to 2'b11, feed z_in=1 -> recovered bit 1; state_dbg=00 next cycle.
- Assert rst mid-word (bit_cnt=3) while out_valid=1 -> out_valid=0, out_data=0, state_dbg=00 immediately, without waiting for a clock edge.
